// File: rtl/mux_sel_arbiter_pkg.sv
// Shared mux_arb_defs definitions for the 4:1 mux select arbiter.
// Holds the requester count, the select width, the FSM encoding and a one-hot helper.
package mux_sel_arbiter_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx2oh(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant/select bundle between the requesters, the arbiter and the 4:1 mux.
// master = arbiter side, slave = requester/mux side.
interface mux_sel_arbiter_if;
    import mux_sel_arbiter_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;

    modport master (input req, output gnt, output sel, output busy);
    modport slave  (output req, input gnt, input sel, input busy);

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode.
// Returns the first set request bit searching ptr, ptr+1, ... modulo NREQ.
module mux_sel_arbiter_rr_pick
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win_idx
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Index arithmetic wraps naturally in SEL_W bits
    always_comb begin
        any     = |req;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                win_idx = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning the 2-bit select of the shared 4:1 core-to-memory mux.
// Optional macro ARB_TIMEOUT_EN: forces release after HOLD_MAX granted cycles when others wait.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_sel_arbiter_if.master bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be in 2..255");
    end

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             any_c;
    logic [SEL_W-1:0] win_idx_c;
    logic             timeout_c;

    mux_sel_arbiter_rr_pick u_rr_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .any     (any_c),
        .win_idx (win_idx_c)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Owner has used its slot and someone else is waiting
    assign timeout_c = (cnt_q == CNT_LAST) && (|(bus.req & ~gnt_q));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // sel_q doubles as the owner index while in GRANT
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    gnt_d   = idx2oh(win_idx_c);
                    sel_d   = win_idx_c;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!bus.req[sel_q] || timeout_c) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                    state_d = ST_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: per-cycle scoreboard against a behavioural model
// plus directed checks; HOLD_MAX=4 when ARB_TIMEOUT_EN is defined.
module tb_mux_sel_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 8;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.HOLD_MAX(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {gnt[3:0], sel[1:0], busy}
    logic [6:0] exp_q[$];

    int         m_phase;
    int         m_own;
    int         m_ptr;
    int         m_cnt;
    logic [3:0] m_gnt;
    logic [1:0] m_sel;
    logic       m_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_own   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_gnt   = 4'b0000;
        m_sel   = 2'b00;
        m_busy  = 1'b0;
    endtask

    // Behavioural reference: phase 0=idle, 1=owned, 2=turnaround
    task automatic model_step(input logic [3:0] r);
        bit rel;
        int s;
        case (m_phase)
            0: begin
                if (r != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        s = (m_ptr + k) % 4;
                        if (r[s]) begin
                            m_own = s;
                            break;
                        end
                    end
                    m_gnt   = 4'b0000;
                    m_gnt[m_own] = 1'b1;
                    m_sel   = 2'(m_own);
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    m_phase = 1;
                end
            end
            1: begin
                rel = !r[m_own];
`ifdef ARB_TIMEOUT_EN
                if (!rel) begin
                    if (m_cnt >= HM - 1) begin
                        if ((r & ~(4'b0001 << m_own)) != 4'b0000) rel = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
`endif
                if (rel) begin
                    m_gnt   = 4'b0000;
                    m_busy  = 1'b0;
                    m_ptr   = (m_own + 1) % 4;
                    m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // Drive req on the falling edge, predict, then compare just after the rising edge
    task automatic step(input logic [3:0] r);
        logic [6:0] e;
        int         gi;
        @(negedge clk);
        bus.req = r;
        model_step(r);
        exp_q.push_back({m_gnt, m_sel, m_busy});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt",  32'(bus.gnt),  32'(e[6:3]));
        check("sel",  32'(bus.sel),  32'(e[2:1]));
        check("busy", 32'(bus.busy), 32'(e[0]));
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        check("busy_or_gnt", 32'(bus.busy), 32'(|bus.gnt));
        if (bus.busy) begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (bus.gnt[i]) gi = i;
            check("sel_is_owner", 32'(bus.sel), 32'(gi));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 4'b0000;
        model_reset();
        #1;
        check("rst_gnt",  32'(bus.gnt),  32'd0);
        check("rst_sel",  32'(bus.sel),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] r;
    logic [3:0] held;

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        model_reset();
        do_reset();

        // Single request, one-cycle latency, release and turnaround
        step(4'b0000);
        check("single_idle_gnt", 32'(bus.gnt), 32'd0);
        step(4'b0100);
        check("single_gnt",  32'(bus.gnt),  32'b0100);
        check("single_sel",  32'(bus.sel),  32'b10);
        check("single_busy", 32'(bus.busy), 32'd1);
        step(4'b0000);
        check("single_rel_gnt", 32'(bus.gnt), 32'd0);
        check("single_rel_sel", 32'(bus.sel), 32'b10);
        step(4'b0000);
        check("single_dead_gnt", 32'(bus.gnt), 32'd0);

        // Wrap-around: ptr is 3 after the source-2 grant
        step(4'b1001);
        check("wrap_gnt3", 32'(bus.gnt), 32'b1000);
        check("wrap_sel3", 32'(bus.sel), 32'b11);
        step(4'b0001);
        check("wrap_rel", 32'(bus.gnt), 32'd0);
        step(4'b0001);
        check("wrap_dead", 32'(bus.gnt), 32'd0);
        step(4'b0001);
        check("wrap_gnt0", 32'(bus.gnt), 32'b0001);
        check("wrap_sel0", 32'(bus.sel), 32'b00);
        step(4'b0000);
        step(4'b0000);

        // Round-robin fairness with all four requesting
        do_reset();
        step(4'b1111);
        check("rr_first", 32'(bus.gnt), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            step(4'b1111);
            step(4'b1111);
            step(4'b1111 & ~(4'b0001 << k));
            check("rr_gap1", 32'(bus.gnt), 32'd0);
            step(4'b1111);
            check("rr_gap2", 32'(bus.gnt), 32'd0);
            step(4'b1111);
            check("rr_order", 32'(bus.gnt), 32'(4'b0001 << ((k + 1) % 4)));
        end
        step(4'b0000);
        step(4'b0000);

        // Owner keeps the mux while others arrive
        do_reset();
        step(4'b0010);
        check("hold_gnt", 32'(bus.gnt), 32'b0010);
        for (int k = 0; k < 10; k++) begin
            step(4'b1011);
`ifndef ARB_TIMEOUT_EN
            check("hold_gnt_late", 32'(bus.gnt), 32'b0010);
            check("hold_sel_late", 32'(bus.sel), 32'b01);
`endif
        end
        step(4'b0000);
        step(4'b0000);
        step(4'b0000);

        // Asynchronous reset in the middle of a grant
        do_reset();
        step(4'b0100);
        step(4'b0100);
        check("mid_pre_gnt", 32'(bus.gnt), 32'b0100);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_gnt",  32'(bus.gnt),  32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sel",  32'(bus.sel),  32'd0);
        model_reset();
        #1 rst = 1'b0;
        step(4'b0110);
        check("mid_after_gnt", 32'(bus.gnt), 32'b0010);
        check("mid_after_sel", 32'(bus.sel), 32'b01);
        step(4'b0000);
        step(4'b0000);

`ifdef ARB_TIMEOUT_EN
        // Forced release after HOLD_MAX granted cycles when another source waits
        do_reset();
        step(4'b0011);
        check("to_gnt0", 32'(bus.gnt), 32'b0001);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011);
            check("to_hold", 32'(bus.gnt), 32'b0001);
        end
        step(4'b0011);
        check("to_rel", 32'(bus.gnt), 32'd0);
        step(4'b0011);
        check("to_dead", 32'(bus.gnt), 32'd0);
        step(4'b0011);
        check("to_next", 32'(bus.gnt), 32'b0010);
        step(4'b0000);
        step(4'b0000);

        // No forced release without competition
        do_reset();
        step(4'b0001);
        for (int k = 0; k < 10; k++) begin
            step(4'b0001);
            check("to_alone", 32'(bus.gnt), 32'b0001);
        end
        step(4'b0000);
        step(4'b0000);
`endif

        // Random traffic against the model
        do_reset();
        held = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) held = 4'($urandom_range(0, 15));
            r = held;
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that owns the 2-bit select of the 4:1 data mux (A/B/C/D inputs, sel, Y) on the shared core-to-memory path.
- Four requesters (core0 fetch, core0 data, core1 fetch, core1 data) raise requests; the block grants one at a time and drives the mux sel so Y carries the winner's line.
- Sits directly upstream of the 4:1 mux and drives its select input.

Parameters:
- HOLD_MAX, 8, maximum consecutive granted cycles before forced release. Used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
- NREQ, 4, number of requesters. Fixed at 4 to match the 2-bit mux select; not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per source; bit i high = source i wants the mux; held high for the whole transfer.
- gnt  output 4  one-hot grant; at most one bit set.
- sel  output 2  mux select; equals the index of the current or most recent owner.
- busy output 1  high while any gnt bit is set.

Behaviour:
- All outputs are registered.
- Reset: clears gnt, sel, busy and ptr to 0 and forces state IDLE, asynchronously and immediately.
  - Reset mid-grant drops gnt in the same instant, with no RELEASE cycle.
  - After reset deasserts, arbitration restarts with source 0 at top priority.
- ptr is a 2-bit rotating priority pointer. The search order is ptr, ptr+1, ptr+2, ptr+3, mod 4 (3 wraps to 0).
- FSM states are IDLE, GRANT and RELEASE.
- IDLE:
  - If req is nonzero, pick the first set bit in search order as the winner w.
  - On the next edge: gnt sets bit w only, sel becomes w, busy goes to 1, and the state moves to GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If req is zero, stay in IDLE and hold sel at its last value so the mux output stays stable.
- GRANT:
  - While req[w] stays high, hold gnt, sel and busy unchanged, even if other requests arrive.
  - When req[w] is sampled low: on the next edge gnt clears, busy clears, ptr becomes w+1 mod 4, and the state moves to RELEASE.
  - sel is not changed on release.
- RELEASE:
  - Exactly one dead cycle with no grant, giving mux turnaround. Then move to IDLE unconditionally.
  - Requests seen during RELEASE are not granted until they are evaluated in IDLE.
  - Minimum gap between two grants is therefore 2 cycles.
- Simultaneous requests: resolved by ptr order only. Two sources are never granted in the same cycle.
- req[w] dropping in the same cycle other requests rise: normal release path; the new requests are arbitrated in IDLE using the updated ptr.
- A non-owner request that rises and falls while another source owns the mux is lost. This is legal; requesters must hold req until they see gnt.
- Invariant checked by the bench: gnt is zero or one-hot, busy equals the OR of gnt, and sel equals the index of gnt whenever busy is 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle spent in GRANT.
  - When the counter reaches HOLD_MAX-1 and any other req bit is high, release is forced: the same path as a req[w] drop (gnt clears, ptr becomes w+1, state goes to RELEASE).
  - If no other request is pending, the counter saturates and the grant continues.
- Not defined:
  - No counter logic is present.
  - A grant lasts until req[w] drops, unbounded.

Decomposition:
- Shared package/include mux_arb_defs holds:
  - localparams NREQ=4 and SEL_W=2;
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2.
- Sub-module rr_pick: combinational rotate-and-priority-encode.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any (1 bit) and win_idx[1:0].
  - Instantiated once; unit-tested standalone.

Test Plan:
- Reset then single request: assert rst, release, req=4'b0100 → gnt=4'b0100, sel=2'b10, busy=1 exactly one cycle after req is sampled. Drop req → gnt=0 on the next cycle, then one RELEASE cycle.
- Round-robin fairness: hold req=4'b1111 and have each owner drop and re-raise req after 3 cycles → grant order 0,1,2,3,0. Every gap between grants is 2 cycles with gnt=0.
- Wrap-around: ptr=3 after a source-2 grant, then req=4'b1001 → source 3 granted first (sel=2'b11). Its next release → source 0 (sel=2'b00).
- Hold and late arrivals: source 1 owns, then req becomes 4'b1011 for 10 cycles → gnt stays 4'b0010 and sel stays 2'b01 throughout (macro off).
- Reset mid-grant: source 2 owns and rst pulses asynchronously mid-cycle → gnt=0, busy=0, sel=0 immediately. After release with req=4'b0110, source 1 is granted (ptr=0 search order).
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): source 0 holds req with req=4'b0011 → gnt drops after 4 granted cycles, one RELEASE cycle, then gnt=4'b0010. Same test with req=4'b0001 → no forced release.
